// File: rtl/i2s_dac_tx_if.sv
// Sample-pair source to I2S transmitter bundle: audio samples in, DAC pins out.
// master = note generator / sample source side, slave = transmitter side.
interface i2s_dac_tx_if;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        enable_sound;
  logic        mclk;
  logic        sck;
  logic        lrck;
  logic        sdin;
  logic        sample_strobe;

  modport master (
    output audio_left, audio_right, enable_sound,
    input  mclk, sck, lrck, sdin, sample_strobe
  );

  modport slave (
    input  audio_left, audio_right, enable_sound,
    output mclk, sck, lrck, sdin, sample_strobe
  );
endinterface

// File: rtl/i2s_dac_tx.sv
// I2S stereo DAC transmitter: 512-clk frames of 32 x 16-clk slots, one-bit I2S
// delay, samples captured only at frame start.
module i2s_dac_tx (
  input  logic         clk,
  input  logic         rst_n,
  i2s_dac_tx_if.slave  bus
);

  logic [8:0]  r_cnt;
  logic [31:0] r_shift;
  logic        r_sdin;
  logic        r_strobe;

  logic        w_frame_start;
  logic        w_slot_end;

  // Both decodes look at the current count; the action lands on the edge that
  // moves the counter to 0 (frame) or to the next multiple of 16 (slot).
  assign w_frame_start = (r_cnt == 9'd511);
  assign w_slot_end    = (r_cnt[3:0] == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_sdin   <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= r_cnt + 9'd1;
      r_strobe <= w_frame_start;
      if (w_frame_start) begin
        // Last bit left in the register is the previous frame's right LSB.
        r_sdin  <= r_shift[31];
        r_shift <= bus.enable_sound ? {bus.audio_left, bus.audio_right} : 32'd0;
      end else if (w_slot_end) begin
        r_sdin  <= r_shift[31];
        r_shift <= {r_shift[30:0], 1'b0};
      end
    end
  end

  assign bus.mclk          = r_cnt[1];
  assign bus.sck           = r_cnt[3];
  assign bus.lrck          = r_cnt[8];
  assign bus.sdin          = r_sdin;
  assign bus.sample_strobe = r_strobe;

endmodule
